// File: rtl/estacionamiento_pkg.sv
// Shared parking-lot definitions: window FSM encoding and default sizing constants.
package estacionamiento_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'b00,
    VENTANA = 2'b01,
    ALARMA  = 2'b10
  } estado_ventana_t;

  localparam int CAPACIDAD_DEF       = 16;
  localparam int ALERTA_PERSONAS_DEF = 3;
  localparam int VENTANA_CICLOS_DEF  = 1000;

  function automatic int ancho_de(input int capacidad);
    return $clog2(capacidad + 1);
  endfunction

endpackage

// File: rtl/gestor_ocupacion_if.sv
// Event pulses from the sensor FSM and the occupancy/alarm status returned by the manager.
interface gestor_ocupacion_if #(
  parameter int CAPACIDAD = estacionamiento_pkg::CAPACIDAD_DEF
) ();
  localparam int ANCHO = estacionamiento_pkg::ancho_de(CAPACIDAD);

  logic             auto_entra;
  logic             auto_sale;
  logic             pulso_persona;
  logic             limpiar;
  logic [ANCHO-1:0] ocupados;
  logic [ANCHO-1:0] libres;
  logic             lleno;
  logic             vacio;
  logic             habilitar_entrada;
  logic             error_conteo;
  logic             alarma_persona;

  modport master (
    output auto_entra, auto_sale, pulso_persona, limpiar,
    input  ocupados, libres, lleno, vacio, habilitar_entrada, error_conteo, alarma_persona
  );

  modport slave (
    input  auto_entra, auto_sale, pulso_persona, limpiar,
    output ocupados, libres, lleno, vacio, habilitar_entrada, error_conteo, alarma_persona
  );
endinterface

// File: rtl/detector_personas.sv
// Pedestrian window detector: raises a sticky alarm when ALERTA_PERSONAS pedestrian
// pulses fall inside one VENTANA_CICLOS-cycle window.
//   state   | meaning
//   REPOSO  | no window open, waiting for the first pedestrian pulse
//   VENTANA | window open, counting pedestrian pulses until the timer expires
//   ALARMA  | threshold reached, alarm held until limpiar
module detector_personas
  import estacionamiento_pkg::*;
#(
  parameter int ALERTA_PERSONAS = ALERTA_PERSONAS_DEF,
  parameter int VENTANA_CICLOS  = VENTANA_CICLOS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pulso_persona,
  input  logic limpiar,
  output logic alarma_persona
);
  localparam int CW = $clog2(ALERTA_PERSONAS + 1);
  localparam int TW = $clog2(VENTANA_CICLOS + 1);
  localparam logic [CW-1:0] ALERTA_W = CW'(ALERTA_PERSONAS);
  // The opening pedestrian cycle is already part of the window, so the timer
  // holds the cycles remaining after it; timer == 0 marks the last window cycle.
  localparam logic [TW-1:0] CARGA_W = TW'((VENTANA_CICLOS > 1) ? VENTANA_CICLOS - 2 : 0);

  estado_ventana_t estado;
  logic [CW-1:0]   cnt_p;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   cnt_inc;

  assign cnt_inc = cnt_p + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado         <= REPOSO;
      cnt_p          <= '0;
      timer          <= '0;
      alarma_persona <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (pulso_persona) begin
            if (ALERTA_PERSONAS == 1) begin
              estado         <= ALARMA;
              alarma_persona <= 1'b1;
            end else if (VENTANA_CICLOS > 1) begin
              estado <= VENTANA;
              cnt_p  <= CW'(1);
              timer  <= CARGA_W;
            end
          end
        end
        VENTANA: begin
          if (pulso_persona && (cnt_inc == ALERTA_W)) begin
            estado         <= ALARMA;
            alarma_persona <= 1'b1;
            cnt_p          <= cnt_inc;
          end else if (timer == '0) begin
            estado <= REPOSO;
            cnt_p  <= '0;
          end else begin
            timer <= timer - TW'(1);
            if (pulso_persona) cnt_p <= cnt_inc;
          end
        end
        ALARMA: begin
          if (limpiar) begin
            estado         <= REPOSO;
            alarma_persona <= 1'b0;
            cnt_p          <= '0;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end
endmodule

// File: rtl/gestor_ocupacion.sv
// Parking occupancy manager: saturating space counter, registered flags,
// sticky counting-error flag and the pedestrian window detector.
module gestor_ocupacion
  import estacionamiento_pkg::*;
#(
  parameter int CAPACIDAD       = CAPACIDAD_DEF,
  parameter int ALERTA_PERSONAS = ALERTA_PERSONAS_DEF,
  parameter int VENTANA_CICLOS  = VENTANA_CICLOS_DEF
) (
  input logic             clk,
  input logic             reset,
  gestor_ocupacion_if.slave bus
);
  localparam int ANCHO = ancho_de(CAPACIDAD);
  localparam logic [ANCHO-1:0] CAP_W = ANCHO'(CAPACIDAD);

  logic [ANCHO-1:0] ocupados_q, libres_q, ocup_next;
  logic             lleno_q, vacio_q, habilitar_q, error_q, error_set;

  always_comb begin
    ocup_next = ocupados_q;
    error_set = 1'b0;
    if (bus.auto_entra && !bus.auto_sale) begin
      if (ocupados_q == CAP_W) error_set = 1'b1;
      else                     ocup_next = ocupados_q + ANCHO'(1);
    end else if (bus.auto_sale && !bus.auto_entra) begin
      if (ocupados_q == '0) error_set = 1'b1;
      else                  ocup_next = ocupados_q - ANCHO'(1);
    end
  end

  // Flags come from ocup_next so they change on the same edge as ocupados.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocupados_q  <= '0;
      libres_q    <= CAP_W;
      lleno_q     <= 1'b0;
      vacio_q     <= 1'b1;
      habilitar_q <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      ocupados_q  <= ocup_next;
      libres_q    <= CAP_W - ocup_next;
      lleno_q     <= (ocup_next == CAP_W);
      vacio_q     <= (ocup_next == '0);
      habilitar_q <= (ocup_next != CAP_W);
      if (error_set)        error_q <= 1'b1;
      else if (bus.limpiar) error_q <= 1'b0;
    end
  end

  assign bus.ocupados          = ocupados_q;
  assign bus.libres            = libres_q;
  assign bus.lleno             = lleno_q;
  assign bus.vacio             = vacio_q;
  assign bus.habilitar_entrada = habilitar_q;
  assign bus.error_conteo      = error_q;

  detector_personas #(
    .ALERTA_PERSONAS(ALERTA_PERSONAS),
    .VENTANA_CICLOS (VENTANA_CICLOS)
  ) u_detector (
    .clk           (clk),
    .reset         (reset),
    .pulso_persona (bus.pulso_persona),
    .limpiar       (bus.limpiar),
    .alarma_persona(bus.alarma_persona)
  );
endmodule

// File: tb/tb_gestor_ocupacion.sv
// Randomized + directed bench for gestor_ocupacion against a timestamp-based
// occupancy/window reference model.
module tb_gestor_ocupacion;
  localparam int CAP    = 4;
  localparam int VENT   = 10;
  localparam int ALERTA = 3;

  logic clk;
  logic reset;

  gestor_ocupacion_if #(.CAPACIDAD(CAP)) bus ();

  gestor_ocupacion #(
    .CAPACIDAD      (CAP),
    .ALERTA_PERSONAS(ALERTA),
    .VENTANA_CICLOS (VENT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int occ;
  bit err;
  bit alarm;
  bit win_act;
  int win_ini;
  int cnt;
  int cyc;

  task automatic verificar(input string tag, input int obs, input int esp);
    n_chk++;
    if (obs != esp) begin
      n_fail++;
      $display("FAIL %s obtenido=%0d esperado=%0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic modelo_reset();
    occ = 0; err = 0; alarm = 0; win_act = 0; win_ini = 0; cnt = 0;
  endtask

  task automatic modelo(input bit e, input bit s, input bit p, input bit l);
    bit viol;
    viol = 0;
    if (e && !s) begin
      if (occ == CAP) viol = 1; else occ++;
    end else if (s && !e) begin
      if (occ == 0) viol = 1; else occ--;
    end
    if (viol) err = 1;
    else if (l) err = 0;

    if (alarm) begin
      if (l) begin alarm = 0; win_act = 0; end
    end else if (p) begin
      if (win_act && (cyc <= win_ini + VENT - 1)) begin
        cnt++;
        if (cnt == ALERTA) alarm = 1;
      end else begin
        win_act = 1; win_ini = cyc; cnt = 1;
        if (ALERTA == 1) alarm = 1;
      end
    end
  endtask

  task automatic revisar();
    verificar("ocupados", int'(bus.ocupados), occ);
    verificar("libres",   int'(bus.libres), CAP - occ);
    verificar("lleno",    int'(bus.lleno), int'(occ == CAP));
    verificar("vacio",    int'(bus.vacio), int'(occ == 0));
    verificar("habilitar_entrada", int'(bus.habilitar_entrada), int'(occ != CAP));
    verificar("error_conteo",   int'(bus.error_conteo), int'(err));
    verificar("alarma_persona", int'(bus.alarma_persona), int'(alarm));
  endtask

  task automatic step(input bit e, input bit s, input bit p, input bit l);
    bus.auto_entra    = e;
    bus.auto_sale     = s;
    bus.pulso_persona = p;
    bus.limpiar       = l;
    @(posedge clk);
    modelo(e, s, p, l);
    cyc++;
    #1;
    revisar();
  endtask

  task automatic ocio(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.auto_entra = 0; bus.auto_sale = 0; bus.pulso_persona = 0; bus.limpiar = 0;
    cyc = 0;
    modelo_reset();
    #12;
    revisar();
    reset = 1'b1;

    // fill and overflow
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
    verificar("fill_ocupados", int'(bus.ocupados), 4);
    verificar("fill_error", int'(bus.error_conteo), 1);
    step(0, 0, 0, 1);
    // simultaneous at full
    step(1, 1, 0, 0);
    verificar("simul_lleno_error", int'(bus.error_conteo), 0);
    // drain and underflow
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    verificar("simul_vacio_ocupados", int'(bus.ocupados), 0);
    step(0, 1, 0, 0);
    verificar("underflow_error", int'(bus.error_conteo), 1);
    step(0, 0, 0, 1);
    verificar("limpiar_error", int'(bus.error_conteo), 0);

    // alarm inside window: pedestrian pulses at 0, 4, 9
    step(0, 0, 1, 0); ocio(3);
    step(0, 0, 1, 0); ocio(4);
    step(0, 0, 1, 0);
    verificar("alarma_subida", int'(bus.alarma_persona), 1);
    step(0, 0, 1, 0);
    ocio(2);
    step(0, 0, 1, 1);
    verificar("alarma_limpiada", int'(bus.alarma_persona), 0);
    ocio(2);

    // window expiry: pedestrian pulses at 0, 5, 10; then 12, 14 complete the new window
    step(0, 0, 1, 0); ocio(4);
    step(0, 0, 1, 0); ocio(4);
    step(0, 0, 1, 0);
    verificar("expira_sin_alarma", int'(bus.alarma_persona), 0);
    ocio(1); step(0, 0, 1, 0);
    ocio(1); step(0, 0, 1, 0);
    verificar("nueva_ventana_alarma", int'(bus.alarma_persona), 1);
    step(0, 0, 0, 1);

    // asynchronous reset mid-run
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    #3 reset = 1'b0;
    #2;
    modelo_reset();
    revisar();
    #2 reset = 1'b1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    verificar("reset_sin_pendiente", int'(bus.alarma_persona), 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
